// File: rtl/clk_pkg.sv
// Shared definitions for the clock-setting front end: item select encodings and the
// adjust FSM state type.
package clk_pkg;

  localparam logic [2:0] ITEM_SEC  = 3'b000;
  localparam logic [2:0] ITEM_MIN  = 3'b001;
  localparam logic [2:0] ITEM_HOUR = 3'b010;
  localparam logic [2:0] ITEM_DAY  = 3'b011;
  localparam logic [2:0] ITEM_MON  = 3'b100;
  localparam logic [2:0] ITEM_YEAR = 3'b101;
  localparam logic [2:0] ITEM_RUN  = 3'b111;

  typedef enum logic [2:0] {
    StRun,
    StSec,
    StMin,
    StHour,
    StDay,
    StMon,
    StYear
  } adj_state_e;

  function automatic logic [2:0] state_to_item(input adj_state_e s);
    logic [2:0] item;
    unique case (s)
      StSec:   item = ITEM_SEC;
      StMin:   item = ITEM_MIN;
      StHour:  item = ITEM_HOUR;
      StDay:   item = ITEM_DAY;
      StMon:   item = ITEM_MON;
      StYear:  item = ITEM_YEAR;
      default: item = ITEM_RUN;
    endcase
    return item;
  endfunction

  // Mode button walks the items in a fixed ring that passes back through RUN.
  function automatic adj_state_e next_item_state(input adj_state_e s);
    adj_state_e nxt;
    unique case (s)
      StRun:   nxt = StSec;
      StSec:   nxt = StMin;
      StMin:   nxt = StHour;
      StHour:  nxt = StDay;
      StDay:   nxt = StMon;
      StMon:   nxt = StYear;
      default: nxt = StRun;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-FF synchroniser, stable-sample debounce counter, debounced level
// and a one-cycle press event on its rising edge.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/adj_ctrl.sv
// Clock-setting controller: debounced mode/up/down buttons drive the item-select FSM,
// adjust pulses and the gated 1 Hz enable. Auto-repeat on hold under ADJ_AUTO_REPEAT_EN.
module adj_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 20,
  parameter int unsigned HOLD_CYCLES   = 500,
  parameter int unsigned RPT_CYCLES    = 100,
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] select_item,
  output logic       up,
  output logic       down,
  output logic       en_1
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_TICKS + 1);

  logic mode_lvl, up_lvl, down_lvl;
  logic mode_p, up_p, down_p;

  adj_state_e      state_q, state_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            up_q, up_d, down_q, down_d;
  logic            adj, any_press, adj_valid, tmo_fire;
  logic            rpt_fire, rpt_up;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_mode),
    .level_o (mode_lvl),
    .press_o (mode_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_up),
    .level_o (up_lvl),
    .press_o (up_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_down),
    .level_o (down_lvl),
    .press_o (down_p)
  );

  assign adj       = (state_q != StRun);
  assign any_press = mode_p | up_p | down_p;
  // Mode outranks adjust presses; simultaneous up+down cancel each other.
  assign adj_valid = adj & ~mode_p & (up_p ^ down_p);
  // A press or repeat pulse landing on the timeout edge keeps the item selected.
  assign tmo_fire  = adj & tick_1s & (tmo_cnt_q == TmoW'(TIMEOUT_TICKS - 1))
                     & ~any_press & ~rpt_fire;

`ifdef ADJ_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic            rpt_active_q, rpt_active_d;
  logic            rpt_up_q, rpt_up_d;
  logic            rpt_first_q, rpt_first_d;
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RptW-1:0] rpt_limit;
  logic            rpt_held;

  assign rpt_limit = rpt_first_q ? RptW'(HOLD_CYCLES) : RptW'(RPT_CYCLES);
  assign rpt_held  = rpt_up_q ? up_lvl : down_lvl;

  always_comb begin
    rpt_active_d = rpt_active_q;
    rpt_up_d     = rpt_up_q;
    rpt_first_d  = rpt_first_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_fire     = 1'b0;
    if (!adj || mode_p || (up_p && down_p)) begin
      rpt_active_d = 1'b0;
    end else if (up_p || down_p) begin
      rpt_active_d = 1'b1;
      rpt_up_d     = up_p;
      rpt_first_d  = 1'b1;
      rpt_cnt_d    = '0;
    end else if (rpt_active_q) begin
      if (!rpt_held) begin
        rpt_active_d = 1'b0;
      end else if (rpt_cnt_q + RptW'(1) == rpt_limit) begin
        rpt_fire    = 1'b1;
        rpt_first_d = 1'b0;
        rpt_cnt_d   = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_active_q <= 1'b0;
      rpt_up_q     <= 1'b0;
      rpt_first_q  <= 1'b0;
      rpt_cnt_q    <= '0;
    end else begin
      rpt_active_q <= rpt_active_d;
      rpt_up_q     <= rpt_up_d;
      rpt_first_q  <= rpt_first_d;
      rpt_cnt_q    <= rpt_cnt_d;
    end
  end

  assign rpt_up = rpt_up_q;
`else
  assign rpt_fire = 1'b0;
  assign rpt_up   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      tmo_cnt_q <= '0;
      sel_q     <= ITEM_RUN;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      sel_q     <= sel_d;
      up_q      <= up_d;
      down_q    <= down_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      state_d = next_item_state(state_q);
    end else if (tmo_fire) begin
      state_d = StRun;
    end

    tmo_cnt_d = tmo_cnt_q;
    if (!adj || any_press || rpt_fire || (state_d != state_q)) begin
      tmo_cnt_d = '0;
    end else if (tick_1s) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  // Outputs
  always_comb begin
    sel_d  = state_to_item(state_d);
    up_d   = (adj_valid & up_p) | (rpt_fire & rpt_up);
    down_d = (adj_valid & down_p) | (rpt_fire & ~rpt_up);
  end

  assign select_item = sel_q;
  assign up          = up_q;
  assign down        = down_q;
  assign en_1        = tick_1s & (state_q == StRun) & ~rst;

endmodule

// File: tb/tb_adj_ctrl.sv
// Directed bench for adj_ctrl: table of button presses plus hand sequences for reset,
// tick gating, timeout, reset mid-press and long hold.
module tb_adj_ctrl;

  localparam int Lat = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [2:0] select_item;
  logic       up, down, en_1;

  adj_ctrl #(
    .DB_CYCLES     (20),
    .HOLD_CYCLES   (500),
    .RPT_CYCLES    (100),
    .TIMEOUT_TICKS (30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1s     (tick_1s),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .select_item (select_item),
    .up          (up),
    .down        (down),
    .en_1        (en_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         up_log[$];
  int         down_log[$];
  int         sel_log[$];
  logic [2:0] prev_sel = 3'b111;
  logic       both_seen = 1'b0;

  always @(negedge clk) begin
    if (up === 1'b1) up_log.push_back(cyc);
    if (down === 1'b1) down_log.push_back(cyc);
    if (select_item !== prev_sel) sel_log.push_back(cyc);
    prev_sel <= select_item;
    if (up === 1'b1 && down === 1'b1) both_seen <= 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    up_log.delete();
    down_log.delete();
    sel_log.delete();
  endtask

  // Raw level first sampled at edge n; held for len edges.
  task automatic press(input logic m, input logic u, input logic d, input int len,
                       output int n);
    @(posedge clk);
    #1;
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    n = cyc + 1;
    repeat (len) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic send_tick(output int te, output logic en_seen);
    @(posedge clk);
    #1;
    tick_1s = 1'b1;
    te = cyc + 1;
    @(negedge clk);
    en_seen = en_1;
    @(posedge clk);
    #1;
    tick_1s = 1'b0;
    @(posedge clk);
  endtask

  task automatic mode_step();
    int n;
    press(1'b1, 1'b0, 1'b0, 30, n);
    repeat (45) @(posedge clk);
  endtask

  typedef struct {
    logic       m;
    logic       u;
    logic       d;
    int         len;
    logic [2:0] exp_sel;
    int         exp_up;
    int         exp_dn;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, te;
    logic       en_seen;
    logic [2:0] sel_exp_prev;
    int         rpt_exp[$];

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 30, 3'b000, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 40, 3'b000, 1, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 40, 3'b000, 0, 1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 40, 3'b000, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10, 3'b000, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 30, 3'b001, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 30, 3'b010, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 30, 3'b010, 0, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 30, 3'b011, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 30, 3'b100, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 30, 3'b101, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 30, 3'b111, 0, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 40, 3'b111, 0, 0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 40, 3'b111, 0, 0};

    // Reset with tick_1s high: en_1 must stay low.
    rst     = 1'b1;
    tick_1s = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel", int'(select_item), 7);
    check("rst_up", int'(up), 0);
    check("rst_down", int'(down), 0);
    check("rst_en_1", int'(en_1), 0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    tick_1s = 1'b0;
    clear_logs();

    // Three ticks in RUN.
    for (int k = 0; k < 3; k++) begin
      send_tick(te, en_seen);
      check($sformatf("run_tick%0d_en_1", k), int'(en_seen), 1);
      @(negedge clk);
      check($sformatf("run_idle%0d_en_1", k), int'(en_1), 0);
    end
    check("run_ticks_pulses", up_log.size() + down_log.size(), 0);
    check("run_ticks_sel", int'(select_item), 7);

    // Table of presses.
    sel_exp_prev = 3'b111;
    for (int i = 0; i < 14; i++) begin
      clear_logs();
      press(vecs[i].m, vecs[i].u, vecs[i].d, vecs[i].len, n);
      repeat (45) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_sel", i), int'(select_item), int'(vecs[i].exp_sel));
      check($sformatf("vec%0d_nup", i), up_log.size(), vecs[i].exp_up);
      check($sformatf("vec%0d_ndown", i), down_log.size(), vecs[i].exp_dn);
      if (vecs[i].exp_up > 0 && up_log.size() > 0)
        check($sformatf("vec%0d_up_lat", i), up_log[0] - n, Lat);
      if (vecs[i].exp_dn > 0 && down_log.size() > 0)
        check($sformatf("vec%0d_down_lat", i), down_log[0] - n, Lat);
      if (vecs[i].exp_sel != sel_exp_prev) begin
        check($sformatf("vec%0d_nsel_chg", i), sel_log.size(), 1);
        if (sel_log.size() > 0)
          check($sformatf("vec%0d_sel_lat", i), sel_log[0] - n, Lat);
      end else begin
        check($sformatf("vec%0d_nsel_chg", i), sel_log.size(), 0);
      end
      sel_exp_prev = vecs[i].exp_sel;
    end

    // Timeout from HOUR with no activity; tick in adjust state keeps en_1 low.
    repeat (3) mode_step();
    @(negedge clk);
    check("tmo_hour_sel", int'(select_item), 2);
    clear_logs();
    send_tick(te, en_seen);
    check("adj_tick_en_1", int'(en_seen), 0);
    for (int k = 1; k < 29; k++) send_tick(te, en_seen);
    @(negedge clk);
    check("tmo_29_sel", int'(select_item), 2);
    send_tick(te, en_seen);
    @(negedge clk);
    check("tmo_30_sel", int'(select_item), 7);
    check("tmo_30_nchg", sel_log.size(), 1);
    if (sel_log.size() > 0) check("tmo_30_edge", sel_log[0], te);

    // A press before the 30th tick restarts the count.
    mode_step();
    clear_logs();
    for (int k = 0; k < 20; k++) send_tick(te, en_seen);
    press(1'b0, 1'b1, 1'b0, 30, n);
    repeat (45) @(posedge clk);
    check("tmo_rst_nup", up_log.size(), 1);
    for (int k = 0; k < 29; k++) send_tick(te, en_seen);
    @(negedge clk);
    check("tmo_rst_29_sel", int'(select_item), 0);
    send_tick(te, en_seen);
    @(negedge clk);
    check("tmo_rst_30_sel", int'(select_item), 7);

    // Reset mid-press discards the press; 15 post-reset cycles are not enough.
    clear_logs();
    @(posedge clk);
    #1;
    btn_mode = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("rst_mid_sel", int'(select_item), 7);
    check("rst_mid_nchg", sel_log.size(), 0);

    // Long hold of up in SEC.
    mode_step();
    clear_logs();
    press(1'b0, 1'b1, 1'b0, 1000, n);
    repeat (60) @(posedge clk);
    @(negedge clk);
`ifdef ADJ_AUTO_REPEAT_EN
    rpt_exp = '{23, 523, 623, 723, 823, 923};
`else
    rpt_exp = '{23};
`endif
    check("hold_nup", up_log.size(), rpt_exp.size());
    for (int k = 0; k < rpt_exp.size(); k++) begin
      if (k < up_log.size()) check($sformatf("hold_up%0d_edge", k), up_log[k] - n, rpt_exp[k]);
    end
    check("hold_ndown", down_log.size(), 0);
    check("hold_sel", int'(select_item), 0);

    check("up_down_exclusive", int'(both_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
